// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the matrix-multiply MAC sequencer.
package mac_sequencer_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/mac_addr_gen.sv
// i/j/k loop counters and row-major A, B, C address arithmetic for C = A x B.
module mac_addr_gen
   import mac_sequencer_pkg::*;
#(
   parameter int N  = 4,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   input  logic          k_inc,
   input  logic          elem_adv,
   output logic          k_end,
   output logic          elem_last,
   output logic [AW-1:0] a_addr,
   output logic [AW-1:0] b_addr,
   output logic [AW-1:0] c_addr
);

   // k runs one ahead of the consumed index and reaches N+1, so size for N+2
   localparam int CW = $clog2(N + 2);

   logic [CW-1:0] i, j, k;

   always_ff @(posedge clk) begin
      if (reset || init) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (elem_adv) begin
         k <= '0;
         if (j == CW'(N - 1)) begin
            j <= '0;
            i <= (i == CW'(N - 1)) ? '0 : i + CW'(1);
         end else begin
            j <= j + CW'(1);
         end
      end else if (k_inc) begin
         k <= k + CW'(1);
      end
   end

   assign k_end     = (k == CW'(N));
   assign elem_last = (i == CW'(N - 1)) && (j == CW'(N - 1));

   assign a_addr = AW'(i) * AW'(N) + AW'(k);
   assign b_addr = AW'(k) * AW'(N) + AW'(j);
   assign c_addr = AW'(i) * AW'(N) + AW'(j);

endmodule

// File: rtl/mac_sequencer.sv
// Control FSM sequencing an external MAC through C = A x B, one element per N+2 cycles.
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int N  = 4,
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     a_addr,
   output logic [AW-1:0]     b_addr,
   input  logic [DATA_W-1:0] a_rdata,
   input  logic [DATA_W-1:0] b_rdata,
   output logic              mac_clear,
   output logic              mac_enable,
   input  logic [DATA_W-1:0] mac_accum,
   output logic [AW-1:0]     c_addr,
   output logic [DATA_W-1:0] c_wdata,
   output logic              c_we
);

   state_t state;
   logic   k_end, elem_last;
   logic   gen_init, k_inc, elem_adv;

   // Operand data goes straight to the external MAC; only addresses matter here.
   logic   rdata_unused;
   assign rdata_unused = ^{a_rdata, b_rdata};

   assign gen_init = (state == IDLE) && start;
   assign k_inc    = (state == CLEAR) || (state == RUN);
   assign elem_adv = (state == WRITE);

   mac_addr_gen #(
      .N  (N),
      .AW (AW)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .init      (gen_init),
      .k_inc     (k_inc),
      .elem_adv  (elem_adv),
      .k_end     (k_end),
      .elem_last (elem_last),
      .a_addr    (a_addr),
      .b_addr    (b_addr),
      .c_addr    (c_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         mac_clear  <= 1'b1;
         mac_enable <= 1'b0;
         c_we       <= 1'b0;
      end else begin
         mac_clear  <= 1'b0;
         mac_enable <= 1'b0;
         c_we       <= 1'b0;
         done       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  mac_clear <= 1'b1;
               end
            end
            CLEAR: begin
               state      <= RUN;
               mac_enable <= 1'b1;
            end
            RUN: begin
               // k_end marks the last enable; the accumulator is final one cycle later
               if (k_end) begin
                  state <= WRITE;
                  c_we  <= 1'b1;
               end else begin
                  mac_enable <= 1'b1;
               end
            end
            WRITE: begin
               if (elem_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state     <= CLEAR;
                  mac_clear <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign c_wdata = mac_accum;

endmodule

// File: tb/tb_mac_sequencer.sv
// Drives an N=2 and an N=4 sequencer with modelled memories and MAC, checking C against A x B.
module tb_mac_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  start, busy, done, mac_clear, mac_enable, c_we;
   logic [7:0]  a_addr [2];
   logic [7:0]  b_addr [2];
   logic [7:0]  c_addr [2];
   logic [31:0] a_rdata [2];
   logic [31:0] b_rdata [2];
   logic [31:0] accum [2];
   logic [31:0] c_wdata [2];
   logic [31:0] mem_a [2][256];
   logic [31:0] mem_b [2][256];
   logic [39:0] wq0 [$];
   logic [39:0] wq1 [$];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          excl_viol = 0;

   always #5 clk = ~clk;

   mac_sequencer #(.N(2), .AW(8)) dut2 (
      .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .a_addr(a_addr[0]), .b_addr(b_addr[0]), .a_rdata(a_rdata[0]), .b_rdata(b_rdata[0]),
      .mac_clear(mac_clear[0]), .mac_enable(mac_enable[0]), .mac_accum(accum[0]),
      .c_addr(c_addr[0]), .c_wdata(c_wdata[0]), .c_we(c_we[0])
   );

   mac_sequencer #(.N(4), .AW(8)) dut4 (
      .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .a_addr(a_addr[1]), .b_addr(b_addr[1]), .a_rdata(a_rdata[1]), .b_rdata(b_rdata[1]),
      .mac_clear(mac_clear[1]), .mac_enable(mac_enable[1]), .mac_accum(accum[1]),
      .c_addr(c_addr[1]), .c_wdata(c_wdata[1]), .c_we(c_we[1])
   );

   // Synchronous-read memories and the external MAC
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         a_rdata[u] <= mem_a[u][a_addr[u]];
         b_rdata[u] <= mem_b[u][b_addr[u]];
         if (mac_clear[u])
            accum[u] <= 32'd0;
         else if (mac_enable[u])
            accum[u] <= accum[u] + a_rdata[u] * b_rdata[u];
      end
   end

   always @(negedge clk) begin
      if (c_we[0]) wq0.push_back({c_addr[0], c_wdata[0]});
      if (c_we[1]) wq1.push_back({c_addr[1], c_wdata[1]});
      if ((int'(mac_clear[0]) + int'(mac_enable[0]) + int'(c_we[0]) > 1) ||
          (int'(mac_clear[1]) + int'(mac_enable[1]) + int'(c_we[1]) > 1))
         excl_viol <= excl_viol + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int wcount(input int u);
      return (u == 0) ? wq0.size() : wq1.size();
   endfunction

   function automatic logic [39:0] wentry(input int u, input int e);
      return (u == 0) ? wq0[e] : wq1[e];
   endfunction

   task automatic fill_random(input int u, input int n);
      for (int x = 0; x < n * n; x++) begin
         mem_a[u][x] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 7) : $urandom;
         mem_b[u][x] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
      end
   endtask

   // One full job; noisy re-asserts start while busy, always including the DONE cycle.
   task automatic run_job(input int u, input int n, input bit noisy);
      int          cyc;
      int          lat;
      bit          seen;
      logic [31:0] exp_c;
      logic [39:0] w;
      if (u == 0) wq0.delete(); else wq1.delete();
      cyc = 0; lat = 0; seen = 1'b0;
      start[u] = 1'b1;
      while (!seen && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (done[u]) begin
            seen = 1'b1;
            lat  = cyc;
            chk("busy_in_done", busy[u], 1);
            start[u] = noisy;
         end else begin
            start[u] = noisy && ($urandom_range(0, 2) == 0);
         end
      end
      chk("done_seen", seen, 1);
      chk("latency", lat, n * n * (n + 2) + 1);
      @(negedge clk);
      start[u] = 1'b0;
      chk("busy_after_done", busy[u], 0);
      @(negedge clk);
      chk("idle_stays", busy[u], 0);
      chk("wr_count", wcount(u), n * n);
      for (int e = 0; e < wcount(u) && e < n * n; e++) begin
         exp_c = 32'd0;
         for (int kk = 0; kk < n; kk++)
            exp_c = exp_c + mem_a[u][(e / n) * n + kk] * mem_b[u][kk * n + (e % n)];
         w = wentry(u, e);
         chk("c_addr", w[39:32], e);
         chk("c_data", w[31:0], exp_c);
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] exp2 [4];
      logic [39:0] w;
      reset = 1'b1;
      start = '0;
      for (int u = 0; u < 2; u++)
         for (int x = 0; x < 256; x++) begin
            mem_a[u][x] = 32'd0;
            mem_b[u][x] = 32'd0;
         end
      @(negedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_busy", busy[u], 0);
         chk("rst_done", done[u], 0);
         chk("rst_enable", mac_enable[u], 0);
         chk("rst_we", c_we[u], 0);
         chk("rst_clear", mac_clear[u], 1);
      end
      reset = 1'b0;
      @(negedge clk);

      // 2x2 worked example
      mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[0][2] = 3; mem_a[0][3] = 4;
      mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[0][2] = 7; mem_b[0][3] = 8;
      exp2[0] = 19; exp2[1] = 22; exp2[2] = 43; exp2[3] = 50;
      run_job(0, 2, 1'b0);
      for (int e = 0; e < 4 && e < wq0.size(); e++) begin
         w = wq0[e];
         chk("ex2x2", w[31:0], exp2[e]);
      end

      // 4x4 identity times 0..15 reproduces B
      for (int x = 0; x < 16; x++) begin
         mem_a[1][x] = ((x / 4) == (x % 4)) ? 32'd1 : 32'd0;
         mem_b[1][x] = x;
      end
      run_job(1, 4, 1'b0);
      for (int e = 0; e < 16 && e < wq1.size(); e++) begin
         w = wq1[e];
         chk("ident", w[31:0], e);
      end

      // All-ones operands wrap to 2
      for (int x = 0; x < 4; x++) begin
         mem_a[0][x] = 32'hFFFF_FFFF;
         mem_b[0][x] = 32'hFFFF_FFFF;
      end
      run_job(0, 2, 1'b0);
      for (int e = 0; e < 4 && e < wq0.size(); e++) begin
         w = wq0[e];
         chk("wrap", w[31:0], 32'h2);
      end

      // Random operands with spurious start pulses while busy
      for (int r = 0; r < 4; r++) begin
         fill_random(r % 2, (r % 2 == 0) ? 2 : 4);
         run_job(r % 2, (r % 2 == 0) ? 2 : 4, 1'b1);
      end

      // Reset during the RUN of element (1,0)
      fill_random(0, 2);
      wq0.delete();
      start[0] = 1'b1;
      cyc = 0;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
         start[0] = 1'b0;
      end
      chk("mid_run_enable", mac_enable[0], 1);
      chk("mid_run_a_addr", a_addr[0], 3);
      chk("mid_run_b_addr", b_addr[0], 2);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_we", c_we[0], 0);
      chk("mid_rst_clear", mac_clear[0], 1);
      @(negedge clk);
      chk("mid_rst_clear2", mac_clear[0], 1);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_rst_wr_count", wq0.size(), 2);
      chk("mid_rst_idle", busy[0], 0);
      fill_random(0, 2);
      run_job(0, 2, 1'b0);

      chk("exclusive_ctrl", excl_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter N, default 4: square matrix dimension; legal range 2..16.
REQ-002 Parameter AW, default 8: operand/result memory address width; 2^AW SHALL be at least N*N.
REQ-003 Clock and reset: reset is synchronous and active-high; clock is clk.
REQ-004 clk  input  1  clock; all state updates occur on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to compute C = A x B.
REQ-007 busy  output  1  high while a computation is in progress.
REQ-008 done  output  1  one-cycle pulse when the last C element has been written.
REQ-009 a_addr  output  AW  A memory read address, row-major: i*N+k.
REQ-010 b_addr  output  AW  B memory read address, row-major: k*N+j.
REQ-011 a_rdata, b_rdata  input  32  read data, valid one cycle after the address is presented.
REQ-012 mac_clear  output  1  drives the MAC accumulator clear.
REQ-013 mac_enable  output  1  drives the MAC accumulate enable.
REQ-014 mac_accum  input  32  MAC accumulator value.
REQ-015 c_addr  output  AW  C memory write address, i*N+j.
REQ-016 c_wdata  output  32  C write data.
REQ-017 c_we  output  1  C write strobe.

Function
REQ-018 The FSM SHALL have five states: IDLE, CLEAR, RUN, WRITE, DONE.
REQ-019 In IDLE, start=1 SHALL set i=0, j=0 and move to CLEAR; start is ignored in every other state.
REQ-020 CLEAR SHALL last one cycle: mac_clear=1, a_addr=i*N+0, b_addr=0*N+j; next state is RUN with k=0.
REQ-021 RUN SHALL last exactly N cycles with mac_enable=1.
REQ-022 In each RUN cycle, the address for k+1 SHALL be presented, pipelined so that every enable consumes data for consecutive k=0..N-1.
REQ-023 Addresses presented beyond k=N-1 are don't-care.
REQ-024 WRITE SHALL last one cycle: c_we=1, c_addr=i*N+j, c_wdata=mac_accum, which equals the sum over k of A[i][k]*B[k][j] mod 2^32.
REQ-025 After WRITE, j SHALL increment; on j wrap from N-1 to 0, i SHALL increment.
REQ-026 After WRITE, the next state is CLEAR, or DONE if (i,j) was (N-1,N-1).
REQ-027 Each element SHALL take N+2 cycles.
REQ-028 DONE SHALL last one cycle with done=1; next state is IDLE.
REQ-029 busy SHALL be 1 in CLEAR, RUN, WRITE and DONE, and 0 in IDLE.
REQ-030 Arithmetic SHALL be unsigned 32-bit with silent wrap; no overflow flag.
REQ-031 mac_clear, mac_enable and c_we SHALL be mutually exclusive in every cycle.
REQ-032 A start coincident with DONE SHALL be ignored.
REQ-033 start is accepted on the cycle after DONE, when the FSM is in IDLE.

Reset
REQ-034 reset SHALL override all other inputs, including start.
REQ-035 On reset, the FSM SHALL enter IDLE and i, j, k SHALL clear to 0.
REQ-036 On reset, busy, done, mac_enable and c_we SHALL be 0.
REQ-037 On reset, mac_clear SHALL be 1 for the reset cycle(s) so the external accumulator is also cleared.
REQ-038 A reset mid-computation SHALL abandon the computation with no further c_we pulses.

Structure
REQ-039 A shared package SHALL hold the FSM state enumeration and the data width constant (32).
REQ-040 Address generation SHALL be a sub-module, mac_addr_gen, containing the i/j/k counters and the row-major address arithmetic; the FSM stays in mac_sequencer.
REQ-041 The MAC SHALL be instantiated outside this block.

Verification
REQ-042 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> writes 19, 22, 43, 50 at addresses 0..3 in order; done exactly 17 cycles after start.
REQ-043 N=4, A=identity, B=values 0..15 -> C equals B; exactly 16 c_we pulses; busy falls the cycle after done.
REQ-044 N=2, all A and B entries 0xFFFFFFFF -> every C entry equals 2 mod 2^32 = 0x00000002.
REQ-045 start asserted again while busy, including on the DONE cycle -> ignored; C write count unchanged; next start accepted from IDLE.
REQ-046 reset asserted during the RUN of element (1,0) -> next cycle busy=0, no further c_we, mac_clear=1 during reset; a fresh start then produces correct results.
